rx_arp_parse: RTL and testbench

Parametrised receive-side ARP parser that sits between the MAC-layer demux (ethertype 0x0806 stream) and the ARP response/transmit logic. It consumes a big-endian byte stream of configurable bus width and extracts the 28-byte ARP payload on the fly, with no internal FIFO. At end of frame it raises one-cycle request, reply or error results. It supports gratuitous ARP, short and aborted frame detection, and an optional statistics counter bank.

---
 rtl/rx_arp_parse.sv | 152 +++++++++++++++
 tb/tb_rx_arp_parse.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_arp_parse.sv
// rx_arp_parse: streaming ARP payload parser; raises request/reply/error pulses the cycle after end of frame.
// Define ARP_STAT_EN to build the stat_clr/stat_ok/stat_err counter bank.
module rx_arp_parse #(
    parameter int DATA_W     = 32,
    parameter int MAC_ADDR_W = 48,
    parameter int IP_ADDR_W  = 32,
    localparam int BYTES     = DATA_W / 8,
    localparam int MOD_W     = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_vld,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [MOD_W-1:0]      in_mod,
    input  logic [IP_ADDR_W-1:0]  cfg_ip_local,
    input  logic [IP_ADDR_W-1:0]  cfg_ip_pc,
    input  logic                  cfg_pc_chk_en,
    output logic                  ack_en,
    output logic                  get_en,
    output logic [MAC_ADDR_W-1:0] get_mac_pc,
    output logic [IP_ADDR_W-1:0]  get_ip_pc,
    output logic                  flag_grat,
    output logic                  err_vld,
    output logic [6:0]            err_code
`ifdef ARP_STAT_EN
    ,
    input  logic                  stat_clr,
    output logic [15:0]           stat_ok,
    output logic [15:0]           stat_err
`endif
);
    typedef enum logic {IDLE, RECV} state_t;

    state_t                r_state, w_next;
    logic [6:0]            r_cnt, w_base;
    logic [223:0]          r_pkt, w_pkt;
    logic [7:0]            w_len;
    logic [15:0]           w_oper;
    logic [IP_ADDR_W-1:0]  w_spa, w_tpa;
    logic [6:0]            w_code_eval, w_code;
    logic                  w_in_frame, w_eval, w_abort, w_drop, w_short, w_grat;
    logic                  w_no_err, w_ack, w_get, w_err;
    logic                  r_ack, r_get, r_grat, r_err;
    logic [6:0]            r_code;
    logic [MAC_ADDR_W-1:0] r_mac;
    logic [IP_ADDR_W-1:0]  r_ip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = (in_vld & in_eop) ? IDLE : (in_vld & in_sop) ? RECV : r_state;
    end

    assign w_base     = in_sop ? 7'd0 : r_cnt;
    assign w_in_frame = in_vld & (in_sop | (r_state == RECV));
    assign w_len      = {1'b0, w_base} + 8'(BYTES) - 8'(in_mod);

    // Current beat overlaid on the stored payload so the eop beat is judged without an extra cycle
    always_comb begin
        w_pkt = r_pkt;
        for (int i = 0; i < 28; i++)
            for (int b = 0; b < BYTES; b++)
                if (int'(w_base) + b == i) w_pkt[223-8*i -: 8] = in_data[DATA_W-1-8*b -: 8];
    end

    assign w_oper  = w_pkt[175:160];
    assign w_spa   = w_pkt[111 -: IP_ADDR_W];
    assign w_tpa   = w_pkt[IP_ADDR_W-1:0];
    assign w_short = w_len < 8'd28;
    assign w_grat  = w_spa == w_tpa;

    assign w_eval  = in_vld & in_eop & ((r_state == IDLE) ? in_sop : !in_sop);
    assign w_abort = in_vld & in_sop & (r_state == RECV);
    assign w_drop  = w_abort & in_eop;

    assign w_code_eval = {1'b0, w_short,
                          !w_short & (w_oper != 16'd1) & (w_oper != 16'd2),
                          !w_short & !w_grat & (w_tpa != cfg_ip_local),
                          !w_short & cfg_pc_chk_en & (w_spa != cfg_ip_pc),
                          !w_short & (w_pkt[191:176] != 16'h0604),
                          !w_short & (w_pkt[223:192] != 32'h00010800)};
    assign w_no_err = ~|w_code_eval;
    assign w_ack    = w_eval & w_no_err & (w_oper == 16'd1) & !w_grat;
    assign w_get    = w_eval & w_no_err & ((w_oper == 16'd2) | w_grat);
    assign w_err    = w_abort | (w_eval & !w_no_err);
    assign w_code   = w_abort ? {1'b1, r_cnt < 7'd28, 5'b0} : w_err ? w_code_eval : 7'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_pkt  <= '0;
            r_ack  <= 1'b0;
            r_get  <= 1'b0;
            r_grat <= 1'b0;
            r_err  <= 1'b0;
            r_code <= '0;
            r_mac  <= '0;
            r_ip   <= '0;
        end else begin
            if (w_in_frame) begin
                r_pkt <= w_pkt;
                r_cnt <= in_sop ? 7'(BYTES) : (r_cnt > 7'(127 - BYTES)) ? 7'd127 : r_cnt + 7'(BYTES);
            end
            r_ack  <= w_ack;
            r_get  <= w_get;
            r_grat <= w_get & w_grat;
            r_err  <= w_err;
            r_code <= w_code;
            if (w_ack | w_get) begin
                r_mac <= w_pkt[159 -: MAC_ADDR_W];
                r_ip  <= w_spa;
            end
        end
    end

    assign ack_en     = r_ack;
    assign get_en     = r_get;
    assign flag_grat  = r_grat;
    assign err_vld    = r_err;
    assign err_code   = r_code;
    assign get_mac_pc = r_mac;
    assign get_ip_pc  = r_ip;

`ifdef ARP_STAT_EN
    logic [15:0] r_stat_ok, r_stat_err;
    logic [1:0]  w_err_inc;

    // A dropped same-cycle result counts as a second error on top of the abort
    assign w_err_inc = {1'b0, w_err} + {1'b0, w_drop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_ok  <= '0;
            r_stat_err <= '0;
        end else if (stat_clr) begin
            r_stat_ok  <= '0;
            r_stat_err <= '0;
        end else begin
            if ((w_ack | w_get) && r_stat_ok != 16'hFFFF) r_stat_ok <= r_stat_ok + 16'd1;
            r_stat_err <= (17'(r_stat_err) + 17'(w_err_inc) > 17'h0FFFF) ? 16'hFFFF : r_stat_err + 16'(w_err_inc);
        end
    end

    assign stat_ok  = r_stat_ok;
    assign stat_err = r_stat_err;
`endif
endmodule

// File: tb/tb_rx_arp_parse.sv
// tb_rx_arp_parse: directed table vectors plus hand sequences for abort, single-beat and reset corners.
module tb_rx_arp_parse;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_vld, in_sop, in_eop;
    logic [1:0]  in_mod;
    logic [31:0] cfg_ip_local, cfg_ip_pc;
    logic        cfg_pc_chk_en;
    logic        ack_en, get_en, flag_grat, err_vld;
    logic [6:0]  err_code;
    logic [47:0] get_mac_pc;
    logic [31:0] get_ip_pc;

    logic [7:0]  d8;
    logic        v8, s8, e8, m8;
    logic        ack8, get8, grat8, err8;
    logic [6:0]  code8;
    logic [47:0] mac8;
    logic [31:0] ip8;

    always #5 clk = ~clk;

    rx_arp_parse #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_sop(in_sop),
        .in_eop(in_eop), .in_mod(in_mod), .cfg_ip_local(cfg_ip_local), .cfg_ip_pc(cfg_ip_pc),
        .cfg_pc_chk_en(cfg_pc_chk_en), .ack_en(ack_en), .get_en(get_en), .get_mac_pc(get_mac_pc),
        .get_ip_pc(get_ip_pc), .flag_grat(flag_grat), .err_vld(err_vld), .err_code(err_code)
    );

    rx_arp_parse #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_data(d8), .in_vld(v8), .in_sop(s8),
        .in_eop(e8), .in_mod(m8), .cfg_ip_local(cfg_ip_local), .cfg_ip_pc(cfg_ip_pc),
        .cfg_pc_chk_en(cfg_pc_chk_en), .ack_en(ack8), .get_en(get8), .get_mac_pc(mac8),
        .get_ip_pc(ip8), .flag_grat(grat8), .err_vld(err8), .err_code(code8)
    );

    typedef struct {
        logic [31:0] ptype;
        logic [15:0] hl;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [31:0] tpa;
        int          n;
        logic        chk;
        logic [3:0]  res;
        logic [6:0]  code;
    } vec_t;

    vec_t        tbl [14];
    logic [7:0]  fb [64];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [47:0] last_mac;
    logic [31:0] last_ip;

    function automatic vec_t mk(logic [31:0] pt, logic [15:0] hl, logic [15:0] op, logic [47:0] sha,
                                logic [31:0] spa, logic [31:0] tpa, int n, logic chk,
                                logic [3:0] res, logic [6:0] code);
        vec_t v;
        v.ptype = pt; v.hl = hl; v.oper = op; v.sha = sha; v.spa = spa; v.tpa = tpa;
        v.n = n; v.chk = chk; v.res = res; v.code = code;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fill(input vec_t v);
        logic [223:0] p;
        p = {v.ptype, v.hl, v.oper, v.sha, v.spa, 48'h0, v.tpa};
        for (int i = 0; i < 64; i++) fb[i] = (i >= v.n) ? 8'hEE : (i < 28) ? p[223-8*i -: 8] : 8'hAA;
    endtask

    task automatic beat32(input int k, input logic sop, input logic eop, input logic [1:0] mod);
        @(negedge clk);
        in_vld = 1'b1; in_sop = sop; in_eop = eop; in_mod = mod;
        in_data = {fb[4*k], fb[4*k+1], fb[4*k+2], fb[4*k+3]};
    endtask

    task automatic idle;
        @(negedge clk);
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_mod = 2'd0;
    endtask

    task automatic send32(input vec_t v);
        int nb;
        fill(v);
        cfg_pc_chk_en = v.chk;
        nb = (v.n + 3) / 4;
        for (int k = 0; k < nb; k++)
            beat32(k, k == 0, k == nb - 1, (k == nb - 1) ? 2'(4 * nb - v.n) : 2'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_res(input string nm, input logic a, input logic g, input logic gr,
                           input logic e, input logic [6:0] c);
        chk({nm, " ack_en"}, 64'(ack_en), 64'(a));
        chk({nm, " get_en"}, 64'(get_en), 64'(g));
        chk({nm, " flag_grat"}, 64'(flag_grat), 64'(gr));
        chk({nm, " err_vld"}, 64'(err_vld), 64'(e));
        chk({nm, " err_code"}, 64'(err_code), 64'(c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_data = '0; in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_mod = '0;
        d8 = '0; v8 = 1'b0; s8 = 1'b0; e8 = 1'b0; m8 = 1'b0;
        cfg_ip_local = 32'hC0A80001; cfg_ip_pc = 32'hC0A80002; cfg_pc_chk_en = 1'b1;
        last_mac = '0; last_ip = '0;

        tbl[0]  = mk(32'h00010800, 16'h0604, 16'd1, 48'h001122334401, 32'hC0A80002, 32'hC0A80001, 28, 1'b1, 4'b1000, 7'h00);
        tbl[1]  = mk(32'h00010800, 16'h0604, 16'd2, 48'h001122334402, 32'hC0A80002, 32'hC0A80001, 28, 1'b1, 4'b0100, 7'h00);
        tbl[2]  = mk(32'h00010800, 16'h0604, 16'd1, 48'h001122334403, 32'hC0A80002, 32'hC0A80002, 28, 1'b1, 4'b0110, 7'h00);
        tbl[3]  = mk(32'h00010800, 16'h0604, 16'd1, 48'h001122334404, 32'hC0A80002, 32'hC0A80001, 26, 1'b1, 4'b0001, 7'h20);
        tbl[4]  = mk(32'h000186DD, 16'h0604, 16'd1, 48'h001122334405, 32'hC0A80063, 32'hC0A80001, 28, 1'b1, 4'b0001, 7'h05);
        tbl[5]  = mk(32'h000186DD, 16'h0604, 16'd1, 48'h001122334406, 32'hC0A80063, 32'hC0A80001, 28, 1'b0, 4'b0001, 7'h01);
        tbl[6]  = mk(32'h00010800, 16'h0604, 16'd1, 48'h001122334407, 32'hC0A80002, 32'hC0A80009, 28, 1'b1, 4'b0001, 7'h08);
        tbl[7]  = mk(32'h00010800, 16'h0604, 16'd3, 48'h001122334408, 32'hC0A80002, 32'hC0A80001, 28, 1'b1, 4'b0001, 7'h10);
        tbl[8]  = mk(32'h00010800, 16'h0605, 16'd1, 48'h001122334409, 32'hC0A80002, 32'hC0A80001, 28, 1'b1, 4'b0001, 7'h02);
        tbl[9]  = mk(32'h00010800, 16'h0604, 16'd2, 48'h00112233440A, 32'hC0A80002, 32'hC0A80001, 46, 1'b1, 4'b0100, 7'h00);
        tbl[10] = mk(32'h00010800, 16'h0604, 16'd1, 48'h00112233440B, 32'hC0A80002, 32'hC0A80001, 27, 1'b1, 4'b0001, 7'h20);
        tbl[11] = mk(32'h00010800, 16'h0604, 16'd2, 48'h00112233440C, 32'hC0A80077, 32'hC0A80001, 28, 1'b0, 4'b0100, 7'h00);
        tbl[12] = mk(32'h00010800, 16'h0604, 16'd3, 48'h00112233440D, 32'hC0A80063, 32'hC0A80009, 28, 1'b1, 4'b0001, 7'h1C);
        tbl[13] = mk(32'h000186DD, 16'h0605, 16'd7, 48'h00112233440E, 32'hC0A80063, 32'hC0A80009, 20, 1'b1, 4'b0001, 7'h20);

        #12;
        chk_res("reset", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        chk("reset get_mac_pc", 64'(get_mac_pc), 64'h0);
        chk("reset get_ip_pc", 64'(get_ip_pc), 64'h0);
        chk("reset dut8 outputs", 64'({ack8, get8, grat8, err8, code8}), 64'h0);
        @(negedge clk); rst = 1'b0;

        // 8-bit bus: 46-byte reply with 18 bytes of padding
        fill(tbl[9]);
        for (int k = 0; k < 46; k++) begin
            @(negedge clk);
            v8 = 1'b1; s8 = (k == 0); e8 = (k == 45); m8 = 1'b0; d8 = fb[k];
        end
        @(posedge clk); #1;
        chk("w8 get_en", 64'(get8), 64'h1);
        chk("w8 flag/ack/err", 64'({grat8, ack8, err8}), 64'h0);
        chk("w8 get_mac_pc", 64'(mac8), 64'(tbl[9].sha));
        chk("w8 get_ip_pc", 64'(ip8), 64'(tbl[9].spa));
        @(negedge clk); v8 = 1'b0; s8 = 1'b0; e8 = 1'b0;

        // table frames run back-to-back with no idle cycle between them
        for (int i = 0; i < 14; i++) begin
            send32(tbl[i]);
            chk_res($sformatf("vec%0d", i), tbl[i].res[3], tbl[i].res[2], tbl[i].res[1], tbl[i].res[0], tbl[i].code);
            if (tbl[i].res[3] | tbl[i].res[2]) begin
                last_mac = tbl[i].sha;
                last_ip  = tbl[i].spa;
            end
            chk($sformatf("vec%0d get_mac_pc", i), 64'(get_mac_pc), 64'(last_mac));
            chk($sformatf("vec%0d get_ip_pc", i), 64'(get_ip_pc), 64'(last_ip));
        end
        idle;
        @(posedge clk); #1;
        chk_res("pulse width", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00);

        // sop in mid-frame aborts the old frame, then the new request completes
        cfg_pc_chk_en = 1'b1;
        fill(tbl[0]);
        beat32(0, 1'b1, 1'b0, 2'd0);
        beat32(1, 1'b0, 1'b0, 2'd0);
        beat32(2, 1'b0, 1'b0, 2'd0);
        beat32(0, 1'b1, 1'b0, 2'd0);
        @(posedge clk); #1;
        chk_res("abort", 1'b0, 1'b0, 1'b0, 1'b1, 7'h60);
        for (int k = 1; k < 7; k++) beat32(k, 1'b0, k == 6, 2'd0);
        @(posedge clk); #1;
        chk_res("after abort", 1'b1, 1'b0, 1'b0, 1'b0, 7'h00);
        chk("after abort get_mac_pc", 64'(get_mac_pc), 64'(tbl[0].sha));
        idle;

        // single-beat sop|eop in RECV: abort reported, new frame's result dropped
        beat32(0, 1'b1, 1'b0, 2'd0);
        beat32(1, 1'b0, 1'b0, 2'd0);
        beat32(0, 1'b1, 1'b1, 2'd0);
        @(posedge clk); #1;
        chk_res("sop_eop abort", 1'b0, 1'b0, 1'b0, 1'b1, 7'h60);
        idle;
        @(posedge clk); #1;
        chk_res("sop_eop dropped", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00);

        // single-beat frame from IDLE is evaluated directly (4 bytes -> short)
        beat32(0, 1'b1, 1'b1, 2'd0);
        @(posedge clk); #1;
        chk_res("single beat", 1'b0, 1'b0, 1'b0, 1'b1, 7'h20);
        idle;

        // reset mid-frame clears outputs; the frame tail is then discarded in IDLE
        fill(tbl[1]);
        beat32(0, 1'b1, 1'b0, 2'd0);
        beat32(1, 1'b0, 1'b0, 2'd0);
        beat32(2, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        in_vld = 1'b0; rst = 1'b1;
        #1;
        chk_res("mid reset", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        chk("mid reset get_mac_pc", 64'(get_mac_pc), 64'h0);
        chk("mid reset get_ip_pc", 64'(get_ip_pc), 64'h0);
        @(negedge clk); rst = 1'b0;
        for (int k = 3; k < 7; k++) beat32(k, 1'b0, k == 6, 2'd0);
        @(posedge clk); #1;
        chk_res("tail discarded", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        send32(tbl[1]);
        chk_res("post reset reply", 1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
        chk("post reset get_ip_pc", 64'(get_ip_pc), 64'(tbl[1].spa));
        idle;
        idle;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
